// File: rtl/cp0_reg_ctrl_pkg.sv
// CP0 register numbers, field positions, write masks and ExcCode values
// shared by the CP0 register controller and its timer.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int ST_IE   = 0;
    localparam int ST_EXL  = 1;
    localparam int ST_BEV  = 22;
    localparam int CA_BD   = 31;
    localparam int CA_TI   = 30;
    localparam int CA_IP_LO = 8;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bits an MTC0 may change; BadVAddr and unimplemented numbers are read-only.
    function automatic logic [31:0] wr_mask(input logic [4:0] addr);
        case (addr)
            REG_COUNT, REG_COMPARE, REG_EPC: wr_mask = 32'hFFFF_FFFF;
            REG_STATUS:                      wr_mask = STATUS_WMASK;
            REG_CAUSE:                       wr_mask = CAUSE_WMASK;
            default:                         wr_mask = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/cp0_reg_ctrl_if.sv
// Commit-side bus between the pipeline/exception unit and the CP0 register controller.
interface cp0_reg_ctrl_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;
    logic [5:0]  hw_int_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_o;

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i,
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i,
        input  eret_i, hw_int_i,
        output rdata_o, status_o, cause_o, epc_o, int_o
    );

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i,
        output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i,
        output eret_i, hw_int_i,
        input  rdata_o, status_o, cause_o, epc_o, int_o
    );
endinterface

// File: rtl/cp0_count_timer.sv
// Count/Compare timer: free-running Count behind a clock divider, sticky TI on match.
module cp0_count_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [31:0]      count_q, compare_q, count_nxt;
    logic             ti_q, wrap;

    assign wrap      = (div_q == DIV_W'(COUNT_DIV - 1));
    assign count_nxt = count_q + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (count_we) begin
                count_q <= wdata;
                div_q   <= '0;
            end else begin
                div_q <= wrap ? '0 : div_q + DIV_W'(1);
                if (wrap) count_q <= count_nxt;
            end
            // A Compare write clears TI even if a match lands in the same cycle.
            if (compare_we) begin
                compare_q <= wdata;
                ti_q      <= 1'b0;
            end else if (!count_we && wrap && count_nxt == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_reg_ctrl.sv
// Architectural CP0 state: arbitrates exception, ERET and MTC0 commits onto
// BadVAddr/Status/Cause/EPC, hosts the Count/Compare timer and raises int_o.
module cp0_reg_ctrl
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    cp0_reg_ctrl_if.slave   bus
);

    logic [31:0] badvaddr_q, epc_q;
    logic [7:0]  im_q;
    logic        exl_q, ie_q, bd_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  hw_ip_q;

    logic [31:0] count, compare, status_val, cause_val, cur_rd, mask;
    logic        ti, mtc0_win, bypass;
    logic [5:0]  ip_hw;

    assign mtc0_win = bus.we_i & ~bus.exc_valid_i & ~bus.eret_i;

    cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_win && bus.waddr_i == REG_COUNT),
        .compare_we (mtc0_win && bus.waddr_i == REG_COMPARE),
        .wdata      (bus.wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Timer interrupt shares the IP7 line with hw_int_i[5].
    assign ip_hw      = {ti | hw_ip_q[5], hw_ip_q[4:0]};
    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti, 14'b0, ip_hw, ip_sw_q, 1'b0, exc_code_q, 2'b0};

    always_comb begin
        cur_rd = 32'h0;
        case (bus.raddr_i)
            REG_BADVADDR: cur_rd = badvaddr_q;
            REG_COUNT:    cur_rd = count;
            REG_COMPARE:  cur_rd = compare;
            REG_STATUS:   cur_rd = status_val;
            REG_CAUSE:    cur_rd = cause_val;
            REG_EPC:      cur_rd = epc_q;
            default:      cur_rd = 32'h0;
        endcase
    end

    assign mask         = wr_mask(bus.raddr_i);
    assign bypass       = mtc0_win && bus.waddr_i == bus.raddr_i;
    assign bus.rdata_o  = bypass ? ((bus.wdata_i & mask) | (cur_rd & ~mask)) : cur_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            hw_ip_q    <= '0;
        end else begin
            hw_ip_q <= bus.hw_int_i;
            if (bus.exc_valid_i) begin
                // A nested exception keeps the original EPC/BD.
                if (!exl_q) begin
                    epc_q <= bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
                    bd_q  <= bus.exc_bd_i;
                end
                exl_q      <= 1'b1;
                exc_code_q <= bus.exc_code_i;
                if (bus.exc_code_i == EXC_ADEL || bus.exc_code_i == EXC_ADES)
                    badvaddr_q <= bus.exc_badvaddr_i;
            end else if (bus.eret_i) begin
                exl_q <= 1'b0;
            end else if (bus.we_i) begin
                case (bus.waddr_i)
                    REG_STATUS: begin
                        im_q  <= bus.wdata_i[15:8];
                        exl_q <= bus.wdata_i[ST_EXL];
                        ie_q  <= bus.wdata_i[ST_IE];
                    end
                    REG_CAUSE: ip_sw_q <= bus.wdata_i[9:8];
                    REG_EPC:   epc_q   <= bus.wdata_i;
                    default: ;
                endcase
            end
        end
    end

    assign bus.status_o = status_val;
    assign bus.cause_o  = cause_val;
    assign bus.epc_o    = epc_q;
    assign bus.int_o    = ie_q & ~exl_q & |(cause_val[15:8] & im_q);

endmodule

// File: tb/tb_cp0_reg_ctrl.sv
// Directed scoreboard bench for cp0_reg_ctrl (COUNT_DIV = 2).
module tb_cp0_reg_ctrl;
    import cp0_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    localparam int SEL_RD = 0, SEL_ST = 1, SEL_CA = 2, SEL_EPC = 3, SEL_INT = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    cp0_reg_ctrl_if bus ();

    cp0_reg_ctrl #(.COUNT_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SEL_RD:  pick = bus.rdata_o;
            SEL_ST:  pick = bus.status_o;
            SEL_CA:  pick = bus.cause_o;
            SEL_EPC: pick = bus.epc_o;
            default: pick = {31'b0, bus.int_o};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = pick(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we_i           = 1'b0;
        bus.waddr_i        = 5'd0;
        bus.wdata_i        = 32'h0;
        bus.exc_valid_i    = 1'b0;
        bus.exc_code_i     = 5'd0;
        bus.exc_pc_i       = 32'h0;
        bus.exc_bd_i       = 1'b0;
        bus.exc_badvaddr_i = 32'h0;
        bus.eret_i         = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.wdata_i = d;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic [31:0] bva);
        bus.exc_valid_i    = 1'b1;
        bus.exc_code_i     = code;
        bus.exc_pc_i       = pc;
        bus.exc_bd_i       = bd;
        bus.exc_badvaddr_i = bva;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        bus.raddr_i  = 5'd0;
        bus.hw_int_i = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        push("rst_status", SEL_ST, 32'h0040_0000);
        push("rst_cause", SEL_CA, 32'h0);
        push("rst_epc", SEL_EPC, 32'h0);
        push("rst_int", SEL_INT, 32'h0);
        push("rst_rdata0", SEL_RD, 32'h0);
        drain();
        rst = 1'b1;

        // Status all-ones: bypass and committed value keep only writable bits plus BEV
        mtc0(REG_STATUS, 32'hFFFF_FFFF);
        bus.raddr_i = REG_STATUS;
        push("status_bypass", SEL_RD, 32'h0040_FF03);
        drain();
        tick(); idle();
        push("status_ones", SEL_ST, 32'h0040_FF03);
        push("int_masked_exl", SEL_INT, 32'h0);
        drain();
        mtc0(REG_STATUS, 32'h0000_FF01);
        tick(); idle();
        push("status_ie", SEL_ST, 32'h0040_FF01);
        drain();

        // Timer: Compare=10, Count=0 -> TI after 20 cycles
        mtc0(REG_COMPARE, 32'd10);
        tick();
        mtc0(REG_COUNT, 32'd0);
        tick(); idle();
        repeat (19) tick();
        bus.raddr_i = REG_COUNT;
        push("count_9", SEL_RD, 32'd9);
        push("ti_early", SEL_CA, 32'h0);
        push("int_early", SEL_INT, 32'h0);
        drain();
        tick();
        push("count_10", SEL_RD, 32'd10);
        push("ti_set", SEL_CA, 32'h4000_8000);
        push("int_timer", SEL_INT, 32'h1);
        drain();
        mtc0(REG_COMPARE, 32'd100);
        tick(); idle();
        push("ti_cleared", SEL_CA, 32'h0);
        push("int_cleared", SEL_INT, 32'h0);
        drain();

        // Exception in a delay slot with an address error
        exc(EXC_ADEL, 32'h8000_0104, 1'b1, 32'h0000_1235);
        tick(); idle();
        bus.raddr_i = REG_BADVADDR;
        push("exc1_epc", SEL_EPC, 32'h8000_0100);
        push("exc1_cause", SEL_CA, 32'h8000_0010);
        push("exc1_status", SEL_ST, 32'h0040_FF03);
        push("exc1_badvaddr", SEL_RD, 32'h0000_1235);
        push("exc1_int", SEL_INT, 32'h0);
        drain();

        // Nested exception: EPC/BD/BadVAddr untouched
        exc(EXC_OV, 32'h8000_0200, 1'b0, 32'h0000_9999);
        tick(); idle();
        push("exc2_epc", SEL_EPC, 32'h8000_0100);
        push("exc2_cause", SEL_CA, 32'h8000_0030);
        push("exc2_badvaddr", SEL_RD, 32'h0000_1235);
        drain();

        bus.eret_i = 1'b1;
        tick(); idle();
        push("eret_status", SEL_ST, 32'h0040_FF01);
        drain();

        // Exception beats a same-cycle MTC0 EPC; bypass suppressed
        exc(EXC_SYS, 32'h8000_0300, 1'b0, 32'h0);
        mtc0(REG_EPC, 32'h0000_DEAD);
        bus.raddr_i = REG_EPC;
        push("exc3_no_bypass", SEL_RD, 32'h8000_0100);
        drain();
        tick(); idle();
        push("exc3_epc", SEL_EPC, 32'h8000_0300);
        push("exc3_cause", SEL_CA, 32'h0000_0020);
        push("exc3_status", SEL_ST, 32'h0040_FF03);
        drain();

        // ERET beats a same-cycle MTC0 Status
        bus.eret_i = 1'b1;
        mtc0(REG_STATUS, 32'h0);
        bus.raddr_i = REG_STATUS;
        push("eret_no_bypass", SEL_RD, 32'h0040_FF03);
        drain();
        tick(); idle();
        push("eret_wins", SEL_ST, 32'h0040_FF01);
        drain();

        // Count wrap
        mtc0(REG_COUNT, 32'hFFFF_FFFF);
        bus.raddr_i = REG_COUNT;
        push("count_bypass", SEL_RD, 32'hFFFF_FFFF);
        drain();
        tick(); idle();
        push("count_hold0", SEL_RD, 32'hFFFF_FFFF);
        drain();
        tick();
        push("count_hold1", SEL_RD, 32'hFFFF_FFFF);
        drain();
        tick();
        push("count_wrap", SEL_RD, 32'h0);
        drain();

        // Unimplemented register
        mtc0(5'd3, 32'h0000_1234);
        bus.raddr_i = 5'd3;
        push("unimpl_bypass", SEL_RD, 32'h0);
        drain();
        tick(); idle();
        push("unimpl_read", SEL_RD, 32'h0);
        drain();

        // hw interrupt line 2 -> IP4, one cycle latency
        bus.hw_int_i = 6'b000100;
        push("hw_int_lat", SEL_INT, 32'h0);
        drain();
        tick();
        push("hw_int", SEL_INT, 32'h1);
        push("hw_cause", SEL_CA, 32'h0000_1020);
        drain();

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst = 1'b0;
        push("arst_int", SEL_INT, 32'h0);
        push("arst_status", SEL_ST, 32'h0040_0000);
        push("arst_cause", SEL_CA, 32'h0);
        push("arst_epc", SEL_EPC, 32'h0);
        drain();
        bus.hw_int_i = 6'd0;
        tick();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_reg_ctrl.md
# cp0_reg_ctrl

Owns the architectural CP0 state: BadVAddr, Count, Compare, Status, Cause and EPC. It takes the MTC0 write stream produced in EX and retired at WB. It also accepts exception and ERET commits and runs the Count/Compare timer. It arbitrates all of these onto the register state with a fixed priority and drives the interrupt request to the exception unit.

## Interface
Parameters:
- `COUNT_DIV`, default 2: core cycles per Count increment (1 or 2).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `we_i`  in  1  MTC0 commit strobe.
- `waddr_i`  in  5  CP0 register number.
- `wdata_i`  in  32  write data.
- `raddr_i`  in  5  MFC0 read register number.
- `rdata_o`  out  32  read data, combinational.
- `exc_valid_i`  in  1  exception commit.
- `exc_code_i`  in  5  ExcCode.
- `exc_pc_i`  in  32  PC of the faulting instruction.
- `exc_bd_i`  in  1  the faulting instruction is in a delay slot.
- `exc_badvaddr_i`  in  32  faulting address.
- `eret_i`  in  1  ERET commit.
- `hw_int_i`  in  6  external interrupt lines, level-sensitive.
- `status_o`, `cause_o`, `epc_o`  out  32 each  current register values.
- `int_o`  out  1  interrupt request.

## Operation
- **Registers.** Implemented registers are 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. All other addresses read 0 and ignore writes.
- **Status fields.**
  - Writable: IM[15:8], EXL[1], IE[0].
  - BEV[22] reads 1 and is read-only.
  - All other bits read 0.
- **Cause fields.**
  - Read-only: BD[31], TI[30], IP[15:10], ExcCode[6:2].
  - IP[15:10] = {TI | hw_int_i[5], hw_int_i[4:0]}, resampled into a register every cycle.
  - IP[9:8] are software-writable.
  - All other bits read 0.
- **Write priority per cycle:** exc_valid_i > eret_i > we_i.
  - A lower-priority event in the same cycle is dropped entirely; the killed instruction is not retried here.
  - Count increment and hw IP sampling proceed regardless of the winning event.
- **Exception commit.**
  - If EXL=0: EPC ← exc_bd_i ? exc_pc_i−4 : exc_pc_i, and BD ← exc_bd_i.
  - If EXL=1: EPC and BD are unchanged.
  - In both cases EXL ← 1 and ExcCode ← exc_code_i.
  - BadVAddr ← exc_badvaddr_i only for ExcCode 4 (AdEL) or 5 (AdES).
- **ERET commit:** EXL ← 0.
- **Timer.**
  - A divider counts to COUNT_DIV; Count += 1 (mod 2^32) on each wrap.
  - TI is set in the cycle the incremented Count equals Compare.
  - TI stays set until Compare is written.
  - An MTC0 write to Count overrides the increment and clears the divider.
  - An MTC0 write to Compare clears TI; if a match occurs in that same cycle, the clear wins.
- **Interrupt:** int_o = IE & ~EXL & |(Cause[15:8] & Status[15:8]), computed from registered state.
- **Read bypass.** If we_i and waddr_i==raddr_i, rdata_o returns wdata_i masked to the writable bits merged with current read-only bits.
  - The bypass is suppressed when exc_valid_i or eret_i is high.
  - Reads of Count and Compare bypass the same way.

## Timing
- Reset values:
  - Count 0, Compare 0, Status 0x0040_0000, Cause 0, EPC 0, BadVAddr 0, divider 0.
  - int_o 0, rdata_o 0 for address 0.
- All state updates take effect at the clk edge after the request. status_o, cause_o and epc_o reflect the update one cycle later.
- An exception's effect on int_o is visible one cycle after exc_valid_i; EXL=1 masks interrupts from that point.
- hw_int_i reaches int_o with 1 cycle latency.
- Reset may assert at any point. All state returns to reset values immediately; there is no pending-write replay.

## Structure
- `cp0_pkg` holds:
  - register numbers;
  - Status/Cause bit positions;
  - writable-bit masks;
  - ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12).
- Sub-module `cp0_count_timer` holds Count, Compare, the divider and TI. Its interface is:
  - inputs: write strobes for Count and Compare, plus write data;
  - outputs: count, compare, ti.

## Test plan
- Reset, then MTC0 Status=0xFFFF_FFFF → Status reads 0x0040_FF03.
- MTC0 Compare=10 with Count=0 and COUNT_DIV=2 → TI and IP7 set ~20 cycles later; int_o=1 with IE=1, IM7=1, EXL=0; writing Compare clears TI and deasserts int_o the next cycle.
- Exception with code 4, pc 0x8000_0104, bd=1, badvaddr 0x1235 → EPC 0x8000_0100, BD=1, ExcCode=4, BadVAddr 0x1235, EXL=1; a second exception leaves EPC unchanged; ERET clears EXL.
- Same-cycle exc_valid_i and MTC0 EPC=0xDEAD → EPC takes the exception value; 0xDEAD is dropped.
- MTC0 Count=0xFFFF_FFFF → Count wraps to 0 after COUNT_DIV cycles; the read bypass returns 0xFFFF_FFFF in the write cycle.
- hw_int_i[2]=1 with IM4=1 and IE=1 → int_o=1 after 1 cycle; asserting rst mid-run clears all state and int_o immediately.
